// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra shortest-path engine and its helpers.
package dijkstra_pkg;

  localparam int DEF_MAX_NODES   = 16;
  localparam int DEF_INDEX_WIDTH = 4;
  localparam int DEF_VALUE_WIDTH = 8;
  localparam int DEF_LANES       = 2;
  localparam int DEF_MADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SELECT,
    ST_FETCH,
    ST_DONE
  } state_e;

  function automatic logic [31:0] all_ones(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
  endfunction

  // All-ones distance marks "no edge" and "unreached".
  function automatic logic [31:0] inf_value(input int value_width);
    return all_ones(value_width);
  endfunction

  // All-ones index marks "no predecessor".
  function automatic logic [31:0] no_prev_index(input int index_width);
    return all_ones(index_width);
  endfunction

endpackage

// File: rtl/dijkstra_argmin.sv
// Combinational minimum search over (value, valid) pairs; the lowest index wins ties.
module dijkstra_argmin
  import dijkstra_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_MAX_NODES,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic [VALUE_WIDTH-1:0] values [NUM_ENTRIES],
  input  logic [NUM_ENTRIES-1:0] valid,
  output logic [INDEX_WIDTH-1:0] min_index,
  output logic                   found
);

  logic [VALUE_WIDTH-1:0] best;

  // Strict less-than keeps the earliest candidate on equal values.
  always_comb begin
    found     = 1'b0;
    best      = '0;
    min_index = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid[i] && (!found || (values[i] < best))) begin
        found     = 1'b1;
        best      = values[i];
        min_index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/dijkstra_engine.sv
// Single-source shortest-path engine reading a packed adjacency matrix from memory.
// Optional macro DIJKSTRA_EARLY_EXIT_EN stops the search once the destination is selected.
module dijkstra_engine
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = DEF_MAX_NODES,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int MADDR_WIDTH = DEF_MADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [INDEX_WIDTH-1:0]       source,
  input  logic [INDEX_WIDTH-1:0]       destination,
  input  logic [INDEX_WIDTH-1:0]       number_of_nodes,
  input  logic [MADDR_WIDTH-1:0]       base_address,
  output logic                         mem_read_enable,
  output logic [MADDR_WIDTH-1:0]       mem_addr,
  input  logic                         mem_read_ready,
  input  logic [LANES*VALUE_WIDTH-1:0] mem_read_data,
  output logic                         busy,
  output logic                         done,
  output logic                         reachable,
  output logic                         error,
  output logic [VALUE_WIDTH-1:0]       distance,
  input  logic [INDEX_WIDTH-1:0]       prev_read_index,
  output logic [INDEX_WIDTH-1:0]       prev_read_node
);

  localparam logic [VALUE_WIDTH-1:0] INF     = VALUE_WIDTH'(inf_value(VALUE_WIDTH));
  localparam logic [INDEX_WIDTH-1:0] NO_PREV = INDEX_WIDTH'(no_prev_index(INDEX_WIDTH));
  localparam int WORD_WIDTH = INDEX_WIDTH + 1;
  localparam int OFF_WIDTH  = 2 * INDEX_WIDTH + 1;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] src_q, src_d;
  logic [INDEX_WIDTH-1:0] dst_q, dst_d;
  logic [INDEX_WIDTH-1:0] n_q, n_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0]  row_words_q, row_words_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [VALUE_WIDTH-1:0] cur_dist_q, cur_dist_d;
  logic                   error_q, error_d;
  logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_q, visited_d;

  logic [MAX_NODES-1:0]   cand_valid;
  logic [INDEX_WIDTH-1:0] min_idx;
  logic                   min_found;
  logic                   n_over_cap;
  logic                   prev_out_of_range;
  logic [VALUE_WIDTH-1:0] dist_dst;

  // Range checks against MAX_NODES only exist when the index width can exceed it.
  generate
    if (MAX_NODES < (1 << INDEX_WIDTH)) begin : g_cap_check
      assign n_over_cap        = (n_q > INDEX_WIDTH'(MAX_NODES));
      assign prev_out_of_range = (prev_read_index >= INDEX_WIDTH'(MAX_NODES));
    end else begin : g_no_cap_check
      assign n_over_cap        = 1'b0;
      assign prev_out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < MAX_NODES; i++) begin
      cand_valid[i] = !visited_q[i] && (dist_q[i] != INF) && (i < int'(n_q));
    end
  end

  dijkstra_argmin #(
    .NUM_ENTRIES (MAX_NODES),
    .VALUE_WIDTH (VALUE_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_argmin (
    .values    (dist_q),
    .valid     (cand_valid),
    .min_index (min_idx),
    .found     (min_found)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      row_words_q <= '0;
      word_q      <= '0;
      cur_q       <= '0;
      cur_dist_q  <= '0;
      error_q     <= 1'b0;
      visited_q   <= '0;
      // NOTE: the tables are small flop arrays, not RAM, so they take reset;
      // prev must read NO_PREV straight out of reset.
      for (int i = 0; i < MAX_NODES; i++) begin
        dist_q[i] <= INF;
        prev_q[i] <= NO_PREV;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      n_q         <= n_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      row_words_q <= row_words_d;
      word_q      <= word_d;
      cur_q       <= cur_d;
      cur_dist_q  <= cur_dist_d;
      error_q     <= error_d;
      visited_q   <= visited_d;
      dist_q      <= dist_d;
      prev_q      <= prev_d;
    end
  end

  int                     node;
  int                     rw;
  logic [INDEX_WIDTH-1:0] ni;
  logic [VALUE_WIDTH-1:0] w;
  logic [VALUE_WIDTH:0]   alt;
  logic [OFF_WIDTH-1:0]   row_off;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case statement can infer a latch.
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    n_d         = n_q;
    base_d      = base_q;
    addr_d      = addr_q;
    row_words_d = row_words_q;
    word_d      = word_q;
    cur_d       = cur_q;
    cur_dist_d  = cur_dist_q;
    error_d     = error_q;
    visited_d   = visited_q;
    dist_d      = dist_q;
    prev_d      = prev_q;
    node        = 0;
    rw          = 0;
    ni          = '0;
    w           = '0;
    alt         = '0;
    row_off     = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          src_d   = source;
          dst_d   = destination;
          n_d     = number_of_nodes;
          base_d  = base_address;
          error_d = 1'b0;
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        rw          = (int'(n_q) + LANES - 1) / LANES;
        row_words_d = WORD_WIDTH'(rw);
        if ((n_q == '0) || n_over_cap || (src_q >= n_q) || (dst_q >= n_q)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          for (int i = 0; i < MAX_NODES; i++) begin
            dist_d[i] = INF;
            prev_d[i] = NO_PREV;
          end
          visited_d     = '0;
          dist_d[src_q] = '0;
          state_d       = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!min_found) begin
          state_d = ST_DONE;
        end else begin
          visited_d[min_idx] = 1'b1;
          cur_d              = min_idx;
          cur_dist_d         = dist_q[min_idx];
          word_d             = '0;
          row_off            = OFF_WIDTH'(min_idx) * OFF_WIDTH'(row_words_q);
          addr_d             = base_q + MADDR_WIDTH'(row_off);
`ifdef DIJKSTRA_EARLY_EXIT_EN
          state_d            = (min_idx == dst_q) ? ST_DONE : ST_FETCH;
`else
          state_d            = ST_FETCH;
`endif
        end
      end

      ST_FETCH: begin
        if (mem_read_ready) begin
          for (int j = 0; j < LANES; j++) begin
            node = int'(word_q) * LANES + j;
            ni   = INDEX_WIDTH'(node);
            w    = mem_read_data[j*VALUE_WIDTH +: VALUE_WIDTH];
            if ((node < int'(n_q)) && !visited_q[ni] && (w != INF)) begin
              // The extra top bit catches overflow before the INF comparison.
              alt = {1'b0, cur_dist_q} + {1'b0, w};
              if (!alt[VALUE_WIDTH] && (alt[VALUE_WIDTH-1:0] != INF) &&
                  (alt[VALUE_WIDTH-1:0] < dist_q[ni])) begin
                dist_d[ni] = alt[VALUE_WIDTH-1:0];
                prev_d[ni] = cur_q;
              end
            end
          end
          word_d = word_q + WORD_WIDTH'(1);
          addr_d = addr_q + MADDR_WIDTH'(1);
          if (word_d == row_words_q) begin
            state_d = ST_SELECT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign dist_dst        = dist_q[dst_q];
  assign busy            = (state_q == ST_INIT) || (state_q == ST_SELECT) || (state_q == ST_FETCH);
  assign done            = (state_q == ST_DONE);
  assign error           = error_q;
  assign mem_read_enable = (state_q == ST_FETCH);
  assign mem_addr        = addr_q;
  assign reachable       = done && !error_q && (dist_dst != INF);
  assign distance        = !done ? '0 : (error_q ? INF : dist_dst);
  assign prev_read_node  = prev_out_of_range ? NO_PREV : prev_q[prev_read_index];

endmodule

// File: tb/tb_dijkstra_engine.sv
// Directed self-checking bench for dijkstra_engine with a simple wait-state memory model.
module tb_dijkstra_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  source, destination, number_of_nodes;
  logic [15:0] base_address;
  logic        mem_read_enable;
  logic [15:0] mem_addr;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data;
  logic        busy, done, reachable, error;
  logic [7:0]  distance;
  logic [3:0]  prev_read_index;
  logic [3:0]  prev_read_node;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [7:0]  adj [16][16];
  int          delay = 0;
  int          waits = 0;
  int          reads = 0;
  int          en_cycles = 0;
  int          stall_err = 0;
  logic        stall_pending = 1'b0;
  logic [15:0] stall_addr = '0;

  always #5 clock = ~clock;

  dijkstra_engine dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .source          (source),
    .destination     (destination),
    .number_of_nodes (number_of_nodes),
    .base_address    (base_address),
    .mem_read_enable (mem_read_enable),
    .mem_addr        (mem_addr),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .busy            (busy),
    .done            (done),
    .reachable       (reachable),
    .error           (error),
    .distance        (distance),
    .prev_read_index (prev_read_index),
    .prev_read_node  (prev_read_node)
  );

  assign mem_read_data = mem[mem_addr[7:0]];

  // Ready is decided at the falling edge for the following rising edge.
  always @(negedge clock) begin
    int wn;
    if (!mem_read_enable) begin
      waits          <= 0;
      mem_read_ready <= 1'b0;
    end else begin
      wn = mem_read_ready ? 0 : waits;
      mem_read_ready <= (wn >= delay);
      waits          <= (wn >= delay) ? wn : wn + 1;
    end
  end

  always @(posedge clock) begin
    if (mem_read_enable && mem_read_ready) reads <= reads + 1;
    if (mem_read_enable) en_cycles <= en_cycles + 1;
    if (stall_pending && mem_read_enable && (mem_addr !== stall_addr)) stall_err <= stall_err + 1;
    stall_pending <= mem_read_enable && !mem_read_ready && reset_n;
    stall_addr    <= mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_adj();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        adj[r][c] = 8'hFF;
  endtask

  task automatic load_graph(input logic [15:0] b, input int n);
    int rw;
    logic [15:0] a;
    logic [7:0]  lo, hi;
    rw = (n + 1) / 2;
    for (int r = 0; r < n; r++) begin
      for (int wd = 0; wd < rw; wd++) begin
        a  = b + 16'(r * rw + wd);
        lo = (2 * wd < n) ? adj[r][2*wd] : 8'hFF;
        hi = (2 * wd + 1 < n) ? adj[r][2*wd+1] : 8'hFF;
        mem[a[7:0]] = {hi, lo};
      end
    end
  endtask

  task automatic run_query(input logic [3:0] s, input logic [3:0] d, input logic [3:0] n,
                           input logic [15:0] b, output int cyc, output int nreads,
                           output int nen);
    int r0, e0;
    @(negedge clock);
    source = s; destination = d; number_of_nodes = n; base_address = b; start = 1'b1;
    r0 = reads; e0 = en_cycles;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("no_done_after_start", {31'b0, done}, 32'd0);
    cyc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (busy) cyc++;
      @(negedge clock);
    end
    check("done_reached", {31'b0, done}, 32'd1);
    check("busy_low_in_done", {31'b0, busy}, 32'd0);
    nreads = reads - r0;
    nen    = en_cycles - e0;
  endtask

  task automatic check_prev(input string tag, input logic [3:0] idx, input logic [3:0] exp);
    prev_read_index = idx;
    #1;
    check(tag, {28'b0, prev_read_node}, {28'b0, exp});
  endtask

  int cyc, nreads, nen;

  initial begin
    reset_n = 1'b0; start = 1'b0; source = '0; destination = '0; number_of_nodes = '0;
    base_address = '0; prev_read_index = 4'd5;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    repeat (2) @(negedge clock);

    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_reach", {31'b0, reachable}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_en", {31'b0, mem_read_enable}, 32'd0);
    check("rst_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_dist", {24'b0, distance}, 32'd0);
    check_prev("rst_prev", 4'd5, 4'hF);
    reset_n = 1'b1;

    // Base graph, zero-wait memory.
    clear_adj();
    adj[0][1] = 8'd4; adj[0][2] = 8'd1; adj[2][1] = 8'd2; adj[1][3] = 8'd5;
    load_graph(16'h0040, 4);
    delay = 0;
    run_query(4'd0, 4'd3, 4'd4, 16'h0040, cyc, nreads, nen);
    check("t1_dist", {24'b0, distance}, 32'd8);
    check("t1_reach", {31'b0, reachable}, 32'd1);
    check("t1_error", {31'b0, error}, 32'd0);
    check("t1_reads", nreads, 32'd8);
    check("t1_cycles", cyc, 32'd14);
    check_prev("t1_prev3", 4'd3, 4'd1);
    check_prev("t1_prev1", 4'd1, 4'd2);
    check_prev("t1_prev2", 4'd2, 4'd0);
    check_prev("t1_prev0", 4'd0, 4'hF);

    // Same graph, 3 wait cycles per read, base wrapping past 16'hFFFF.
    load_graph(16'hFFFC, 4);
    delay = 3;
    run_query(4'd0, 4'd3, 4'd4, 16'hFFFC, cyc, nreads, nen);
    check("t2_dist", {24'b0, distance}, 32'd8);
    check("t2_reach", {31'b0, reachable}, 32'd1);
    check("t2_reads", nreads, 32'd8);
    check("t2_cycles", cyc, 32'd38);
    check("t2_addr_stable", stall_err, 32'd0);
    check_prev("t2_prev3", 4'd3, 4'd1);
    check_prev("t2_prev1", 4'd1, 4'd2);

    // Edge 1->3 removed: destination unreachable, back-to-back without reset.
    adj[1][3] = 8'hFF;
    load_graph(16'h0040, 4);
    delay = 0;
    run_query(4'd0, 4'd3, 4'd4, 16'h0040, cyc, nreads, nen);
    check("t3_reach", {31'b0, reachable}, 32'd0);
    check("t3_dist", {24'b0, distance}, 32'hFF);
    check_prev("t3_prev3", 4'd3, 4'hF);
    check_prev("t3_prev1", 4'd1, 4'd2);

    // Invalid operands: N=0, then source out of range.
    run_query(4'd0, 4'd0, 4'd0, 16'h0040, cyc, nreads, nen);
    check("t4a_error", {31'b0, error}, 32'd1);
    check("t4a_reach", {31'b0, reachable}, 32'd0);
    check("t4a_cycles", cyc, 32'd1);
    check("t4a_no_reads", nen, 32'd0);
    run_query(4'd5, 4'd0, 4'd4, 16'h0040, cyc, nreads, nen);
    check("t4b_error", {31'b0, error}, 32'd1);
    check("t4b_cycles", cyc, 32'd1);
    check("t4b_no_reads", nen, 32'd0);

    // Overflow: 200 + 100 does not fit.
    clear_adj();
    adj[0][1] = 8'd200; adj[1][2] = 8'd100;
    load_graph(16'h0080, 3);
    run_query(4'd0, 4'd2, 4'd3, 16'h0080, cyc, nreads, nen);
    check("t5_error", {31'b0, error}, 32'd0);
    check("t5_reach", {31'b0, reachable}, 32'd0);
    check("t5_dist", {24'b0, distance}, 32'hFF);
    check_prev("t5_prev2", 4'd2, 4'hF);
    check_prev("t5_prev1", 4'd1, 4'd0);

    // Sum equal to INF is discarded; INF-1 is kept.
    adj[1][2] = 8'd55;
    load_graph(16'h0080, 3);
    run_query(4'd0, 4'd2, 4'd3, 16'h0080, cyc, nreads, nen);
    check("t6_reach_inf", {31'b0, reachable}, 32'd0);
    adj[1][2] = 8'd54;
    load_graph(16'h0080, 3);
    run_query(4'd0, 4'd2, 4'd3, 16'h0080, cyc, nreads, nen);
    check("t6_reach_254", {31'b0, reachable}, 32'd1);
    check("t6_dist_254", {24'b0, distance}, 32'd254);
    check_prev("t6_prev2", 4'd2, 4'd1);

    // Reset during a stalled FETCH, then a fresh query from another source.
    clear_adj();
    adj[0][1] = 8'd4; adj[0][2] = 8'd1; adj[2][1] = 8'd2; adj[1][3] = 8'd5;
    load_graph(16'h0040, 4);
    delay = 3;
    @(negedge clock);
    source = 4'd0; destination = 4'd3; number_of_nodes = 4'd4; base_address = 16'h0040;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int k;
      for (k = 0; k < 50 && !mem_read_enable; k++) @(negedge clock);
      check("t7_fetch_entered", {31'b0, mem_read_enable}, 32'd1);
    end
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("t7_busy", {31'b0, busy}, 32'd0);
    check("t7_done", {31'b0, done}, 32'd0);
    check("t7_en", {31'b0, mem_read_enable}, 32'd0);
    check("t7_addr", {16'b0, mem_addr}, 32'd0);
    check("t7_dist", {24'b0, distance}, 32'd0);
    check("t7_error", {31'b0, error}, 32'd0);
    check_prev("t7_prev1", 4'd1, 4'hF);
    delay = 0;
    run_query(4'd2, 4'd3, 4'd4, 16'h0040, cyc, nreads, nen);
    check("t7_q_dist", {24'b0, distance}, 32'd7);
    check("t7_q_reach", {31'b0, reachable}, 32'd1);
    check_prev("t7_q_prev3", 4'd3, 4'd1);
    check_prev("t7_q_prev1", 4'd1, 4'd2);
    check_prev("t7_q_prev0", 4'd0, 4'hF);
    check_prev("t7_q_prev2", 4'd2, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
